mem_stage_lsu: RTL and testbench

MEM-stage load/store unit, directly downstream of the EX/MEM pipeline register. It consumes the registered MEM-stage op, funct3, ALU address and store data. It drives a single-port data memory over a req/gnt/rvalid handshake, with byte lanes, write-data replication and load extraction/extension. While an access is outstanding it stalls the pipeline, then presents the aligned load data to the MEM/WB path.

---
 rtl/mem_stage_lsu.sv | 193 +++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit driving a req/gnt/rvalid data memory
//
// Purpose: turns the registered MEM-stage op/funct3/address/store data into a
// single-port data-memory access, stalls the pipeline while the access is in
// flight and presents the extracted, extended load result to the MEM/WB path.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   M_valid, M_op, M_funct3      MEM-stage instruction valid, opcode, size/sign
//   M_alu_out, M_dm_data         effective byte address, store source data
//   dm_req, dm_we, dm_addr       memory request, write enable, word address
//   dm_bweb, dm_wdata            active-low per-bit write mask, replicated data
//   dm_gnt, dm_rvalid, dm_rdata  memory grant, read valid, read data
//   M_ld_data, M_ld_valid        registered load result, one-cycle valid pulse
//   M_stall                      freeze IF..EX/MEM registers
//   M_misalign                   misaligned access flag
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   - misaligned H/W accesses raise M_misalign and issue no request
//   undefined - low address bits beyond the access size are ignored, M_misalign = 0

module mem_stage_lsu #(
  parameter int         DM_AW    = 14,
  parameter logic [6:0] LOAD_OP  = 7'b0000011,
  parameter logic [6:0] STORE_OP = 7'b0100011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             M_valid,
  input  logic [6:0]       M_op,
  input  logic [2:0]       M_funct3,
  input  logic [31:0]      M_alu_out,
  input  logic [31:0]      M_dm_data,
  output logic             dm_req,
  output logic             dm_we,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      dm_bweb,
  output logic [31:0]      dm_wdata,
  input  logic             dm_gnt,
  input  logic             dm_rvalid,
  input  logic [31:0]      dm_rdata,
  output logic [31:0]      M_ld_data,
  output logic             M_ld_valid,
  output logic             M_stall,
  output logic             M_misalign
);

  localparam logic [6:0] FLW_OP = 7'b0000111;
  localparam logic [6:0] FSW_OP = 7'b0100111;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        ld_valid_q, ld_valid_d;

  logic        is_fp, is_load, is_store, access;
  logic        sz_byte, sz_half, sz_word, ld_signed;
  logic [1:0]  a;
  logic [4:0]  lane_sh;
  logic        misalign;
  logic [31:0] st_bweb, st_wdata;
  logic [31:0] rd_shift, ld_ext;
  logic        req, stall, mis;

  // Address bits above the data-memory window are not used by this block.
  logic unused_addr_hi;
  assign unused_addr_hi = ^M_alu_out[31:DM_AW+2];

  // Decode. FP loads/stores are always word accesses regardless of funct3.
  always_comb begin
    is_fp     = (M_op == FLW_OP) || (M_op == FSW_OP);
    is_load   = (M_op == LOAD_OP)  || (M_op == FLW_OP);
    is_store  = (M_op == STORE_OP) || (M_op == FSW_OP);
    access    = M_valid && (is_load || is_store);
    // funct3[1:0]: 00 byte, 01 half, anything else (incl. unknown codes) word
    sz_byte   = !is_fp && (M_funct3[1:0] == 2'b00);
    sz_half   = !is_fp && (M_funct3[1:0] == 2'b01);
    sz_word   = !sz_byte && !sz_half;
    ld_signed = !M_funct3[2];
    a         = M_alu_out[1:0];
    lane_sh   = {a, 3'b000};
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (sz_half && a[0]) || (sz_word && (a != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Store lane mask / replicated data.
  always_comb begin
    st_bweb  = 32'h0000_0000;
    st_wdata = M_dm_data;
    if (sz_byte) begin
      st_bweb  = ~(32'h0000_00FF << lane_sh);
      st_wdata = {4{M_dm_data[7:0]}};
    end else if (sz_half) begin
      st_bweb  = a[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
      st_wdata = {2{M_dm_data[15:0]}};
    end
  end

  // Load extraction and sign/zero extension.
  always_comb begin
    rd_shift = dm_rdata >> lane_sh;
    ld_ext   = dm_rdata;
    if (sz_byte) begin
      ld_ext = {{24{ld_signed & rd_shift[7]}}, rd_shift[7:0]};
    end else if (sz_half) begin
      ld_ext = a[1] ? {{16{ld_signed & dm_rdata[31]}}, dm_rdata[31:16]}
                    : {{16{ld_signed & dm_rdata[15]}}, dm_rdata[15:0]};
    end
  end

  // Next state and control.
  always_comb begin
    state_d    = state_q;
    ld_data_d  = ld_data_q;
    ld_valid_d = 1'b0;
    req        = 1'b0;
    stall      = 1'b0;
    mis        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          if (misalign) begin
            mis = 1'b1;
            if (is_load) ld_data_d = 32'h0000_0000;
          end else begin
            req = 1'b1;
            if (dm_gnt) begin
              // Stores retire in the grant cycle without stalling.
              if (is_load) begin
                state_d = WAIT;
                stall   = 1'b1;
              end
            end else begin
              state_d = REQ;
              stall   = 1'b1;
            end
          end
        end
      end
      REQ: begin
        req   = 1'b1;
        stall = 1'b1;
        if (dm_gnt) state_d = is_store ? DONE : WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (dm_rvalid) begin
          ld_data_d  = ld_ext;
          ld_valid_d = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ld_data_q  <= 32'h0000_0000;
      ld_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_data_q  <= ld_data_d;
      ld_valid_q <= ld_valid_d;
    end
  end

  // Memory-side outputs are combinational from the held MEM-stage inputs, so
  // they stay constant across REQ; gating with rst keeps reset values visible
  // while reset is asserted.
  always_comb begin
    dm_req   = req && !rst;
    dm_we    = dm_req && is_store;
    dm_addr  = dm_req ? M_alu_out[DM_AW+1:2] : '0;
    dm_bweb  = dm_we ? st_bweb : 32'hFFFF_FFFF;
    dm_wdata = dm_we ? st_wdata : 32'h0000_0000;
  end

  assign M_ld_data  = ld_data_q;
  assign M_ld_valid = ld_valid_q;
  assign M_stall    = stall && !rst;
  assign M_misalign = mis && !rst;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - self-checking bench for mem_stage_lsu

module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        M_valid;
  logic [6:0]  M_op;
  logic [2:0]  M_funct3;
  logic [31:0] M_alu_out, M_dm_data;
  logic        dm_req, dm_we;
  logic [13:0] dm_addr;
  logic [31:0] dm_bweb, dm_wdata;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic [31:0] M_ld_data;
  logic        M_ld_valid, M_stall, M_misalign;

  int total = 0;
  int bad   = 0;
  logic [31:0] sbq[$];

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .rst(rst), .M_valid(M_valid), .M_op(M_op), .M_funct3(M_funct3),
    .M_alu_out(M_alu_out), .M_dm_data(M_dm_data), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_bweb(dm_bweb), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .M_ld_data(M_ld_data),
    .M_ld_valid(M_ld_valid), .M_stall(M_stall), .M_misalign(M_misalign)
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    int          gd;     // cycles before gnt
    int          rd;     // cycles from gnt to rvalid (>=1)
    logic [31:0] rdata;
    logic [13:0] eaddr;
    logic [31:0] ebweb;
    logic [31:0] ewdata;
    logic [31:0] eld;
    int          estall;
  } vec_t;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_FLW = 7'b0000111;
  localparam logic [6:0] OP_FSW = 7'b0100111;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int id);
    int  c, stalls, reqs, wrs, lvs;
    bit  done, ld;
    ld = (v.op == OP_LD) || (v.op == OP_FLW);
    @(posedge clk); #1;
    M_valid = 1'b1; M_op = v.op; M_funct3 = v.f3; M_alu_out = v.addr; M_dm_data = v.data;
    dm_rdata = v.rdata;
    if (ld) sbq.push_back(v.eld);
    c = 0; stalls = 0; reqs = 0; wrs = 0; lvs = 0; done = 0;
    while (!done && c < 50) begin
      dm_gnt    = (c == v.gd);
      dm_rvalid = ld && (c == v.gd + v.rd);
      @(negedge clk);
      chk($sformatf("v%0d misalign c%0d", id, c), {31'd0, M_misalign}, 32'd0);
      if (dm_req) begin
        reqs++;
        if (dm_gnt && dm_we) wrs++;
        chk($sformatf("v%0d addr c%0d", id, c), {18'd0, dm_addr}, {18'd0, v.eaddr});
        chk($sformatf("v%0d we c%0d", id, c), {31'd0, dm_we}, {31'd0, !ld});
        chk($sformatf("v%0d bweb c%0d", id, c), dm_bweb, v.ebweb);
        chk($sformatf("v%0d wdata c%0d", id, c), dm_wdata, v.ewdata);
      end
      if (M_ld_valid) begin
        lvs++;
        if (sbq.size() == 0) chk($sformatf("v%0d unexpected ld_valid", id), 32'd1, 32'd0);
        else chk($sformatf("v%0d ld_data", id), M_ld_data, sbq.pop_front());
      end
      if (M_stall) stalls++;
      else done = 1;
      @(posedge clk); #1;
      c++;
    end
    M_valid = 1'b0; dm_gnt = 1'b0; dm_rvalid = 1'b0;
    chk($sformatf("v%0d timeout", id), {31'd0, done}, 32'd1);
    chk($sformatf("v%0d stall cycles", id), stalls, v.estall);
    chk($sformatf("v%0d req cycles", id), reqs, v.gd + 1);
    chk($sformatf("v%0d accepted writes", id), wrs, ld ? 0 : 1);
    chk($sformatf("v%0d ld_valid pulses", id), lvs, ld ? 1 : 0);
    chk($sformatf("v%0d scoreboard empty", id), sbq.size(), 0);
    if (ld) chk($sformatf("v%0d ld_data held", id), M_ld_data, v.eld);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " dm_req"},    {31'd0, dm_req},     32'd0);
    chk({tag, " dm_we"},     {31'd0, dm_we},      32'd0);
    chk({tag, " dm_addr"},   {18'd0, dm_addr},    32'd0);
    chk({tag, " dm_bweb"},   dm_bweb,             32'hFFFF_FFFF);
    chk({tag, " dm_wdata"},  dm_wdata,            32'd0);
    chk({tag, " ld_data"},   M_ld_data,           32'd0);
    chk({tag, " ld_valid"},  {31'd0, M_ld_valid}, 32'd0);
    chk({tag, " stall"},     {31'd0, M_stall},    32'd0);
    chk({tag, " misalign"},  {31'd0, M_misalign}, 32'd0);
  endtask

  vec_t mv;

  initial begin
    //           op      f3      addr          data          gd rd rdata         eaddr    ebweb         ewdata        eld           estall
    vt[0]  = '{OP_ST,  3'b000, 32'h0000_0103, 32'hAABB_CCDD, 0, 1, 32'h0,         14'h040, 32'h00FF_FFFF, 32'hDDDD_DDDD, 32'h0,         0};
    vt[1]  = '{OP_LD,  3'b000, 32'h0000_0102, 32'h0,         0, 2, 32'h12F4_5678, 14'h040, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFF4, 3};
    vt[2]  = '{OP_LD,  3'b101, 32'h0000_0006, 32'h0,         3, 1, 32'h8001_BEEF, 14'h001, 32'hFFFF_FFFF, 32'h0,         32'h0000_8001, 5};
    vt[3]  = '{OP_ST,  3'b010, 32'h0000_0200, 32'h1122_3344, 2, 1, 32'h0,         14'h080, 32'h0000_0000, 32'h1122_3344, 32'h0,         3};
    vt[4]  = '{OP_ST,  3'b001, 32'h0000_000A, 32'h0000_CAFE, 0, 1, 32'h0,         14'h002, 32'h0000_FFFF, 32'hCAFE_CAFE, 32'h0,         0};
    vt[5]  = '{OP_LD,  3'b001, 32'h0000_0010, 32'h0,         1, 1, 32'h1234_8765, 14'h004, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_8765, 3};
    vt[6]  = '{OP_LD,  3'b100, 32'h0000_0001, 32'h0,         0, 1, 32'h0000_9A00, 14'h000, 32'hFFFF_FFFF, 32'h0,         32'h0000_009A, 2};
    vt[7]  = '{OP_LD,  3'b010, 32'h0000_03FC, 32'h0,         0, 3, 32'hDEAD_BEEF, 14'h0FF, 32'hFFFF_FFFF, 32'h0,         32'hDEAD_BEEF, 4};
    vt[8]  = '{OP_FSW, 3'b010, 32'h0000_0024, 32'h4049_0FDB, 1, 1, 32'h0,         14'h009, 32'h0000_0000, 32'h4049_0FDB, 32'h0,         2};
    vt[9]  = '{OP_ST,  3'b000, 32'h0000_0000, 32'h0000_0055, 0, 1, 32'h0,         14'h000, 32'hFFFF_FF00, 32'h5555_5555, 32'h0,         0};
    vt[10] = '{OP_LD,  3'b011, 32'h0000_000C, 32'h0,         0, 1, 32'hCAFE_F00D, 14'h003, 32'hFFFF_FFFF, 32'h0,         32'hCAFE_F00D, 2};
    vt[11] = '{OP_FLW, 3'b010, 32'h0000_0020, 32'h0,         0, 1, 32'h3F80_0000, 14'h008, 32'hFFFF_FFFF, 32'h0,         32'h3F80_0000, 2};

    rst = 1'b1; M_valid = 1'b0; M_op = 7'd0; M_funct3 = 3'd0; M_alu_out = 32'd0;
    M_dm_data = 32'd0; dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'd0;
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1; rst = 1'b0;

    for (int i = 0; i < 12; i++) run(vt[i], i);

    // Bubble and non-memory op: no request, no stall.
    @(posedge clk); #1;
    M_valid = 1'b0; M_op = OP_LD; M_funct3 = 3'b010; M_alu_out = 32'h40; dm_gnt = 1'b1;
    @(negedge clk);
    chk("bubble dm_req", {31'd0, dm_req}, 32'd0);
    chk("bubble stall", {31'd0, M_stall}, 32'd0);
    @(posedge clk); #1;
    M_valid = 1'b1; M_op = 7'b0110011;
    @(negedge clk);
    chk("alu op dm_req", {31'd0, dm_req}, 32'd0);
    chk("alu op stall", {31'd0, M_stall}, 32'd0);
    // Stray rvalid while idle must not produce a load result.
    @(posedge clk); #1;
    M_valid = 1'b0; dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'h1111_1111;
    @(posedge clk); #1; dm_rvalid = 1'b0;
    @(negedge clk);
    chk("idle rvalid ld_valid", {31'd0, M_ld_valid}, 32'd0);
    chk("idle rvalid ld_data", M_ld_data, 32'h3F80_0000);

    // Reset in the middle of WAIT.
    @(posedge clk); #1;
    M_valid = 1'b1; M_op = OP_LD; M_funct3 = 3'b010; M_alu_out = 32'h0000_0040; dm_gnt = 1'b1;
    @(posedge clk); #1; dm_gnt = 1'b0;
    @(negedge clk);
    chk("wait stall", {31'd0, M_stall}, 32'd1);
    chk("wait dm_req", {31'd0, dm_req}, 32'd0);
    #1 rst = 1'b1;
    #1 chk_reset_outputs("mid-wait reset");
    @(posedge clk); #1; rst = 1'b0; M_valid = 1'b0;
    @(negedge clk);
    chk("after reset stall", {31'd0, M_stall}, 32'd0);
    @(posedge clk); #1; dm_rvalid = 1'b1; dm_rdata = 32'h2222_2222;
    @(posedge clk); #1; dm_rvalid = 1'b0;
    @(negedge clk);
    chk("abandoned ld_valid", {31'd0, M_ld_valid}, 32'd0);
    chk("abandoned ld_data", M_ld_data, 32'd0);
    run(vt[1], 100);

    // Misaligned word load at 0x101.
`ifdef LSU_MISALIGN_TRAP_EN
    @(posedge clk); #1;
    M_valid = 1'b1; M_op = OP_LD; M_funct3 = 3'b010; M_alu_out = 32'h0000_0101; dm_gnt = 1'b1;
    @(negedge clk);
    chk("misalign flag", {31'd0, M_misalign}, 32'd1);
    chk("misalign dm_req", {31'd0, dm_req}, 32'd0);
    chk("misalign stall", {31'd0, M_stall}, 32'd0);
    @(posedge clk); #1; M_valid = 1'b0; dm_gnt = 1'b0;
    @(negedge clk);
    chk("misalign ld_data", M_ld_data, 32'd0);
    chk("misalign ld_valid", {31'd0, M_ld_valid}, 32'd0);
`else
    mv = '{OP_LD, 3'b010, 32'h0000_0101, 32'h0, 0, 1, 32'h0102_0304, 14'h040,
           32'hFFFF_FFFF, 32'h0, 32'h0102_0304, 2};
    run(mv, 200);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
